// File: rtl/sram_responder.sv
// sram_responder: word-addressed SRAM target with a 2-entry in-order response FIFO.
//   clk        : single clock, rising edge
//   rst_n      : asynchronous active-low reset (clears FIFO control state only)
//   cmd_valid  / cmd_ready : request handshake; ready whenever the FIFO has a free slot
//   cmd_read   : 1 = read, 0 = write
//   cmd_addr   : byte address; must be word aligned and below 4*DEPTH
//   cmd_wdata  / cmd_wmask : write data and per-byte-lane enables
//   rsp_valid  / rsp_ready : response handshake; response comes from the FIFO head
//   rsp_rdata  / rsp_err   : read data (0 for writes/errors) and error flag
module sram_responder #(
    parameter int DEPTH = 256,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_read,
    input  logic [AW-1:0] cmd_addr,
    input  logic [31:0]   cmd_wdata,
    input  logic [3:0]    cmd_wmask,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err
);
    localparam int IW = $clog2(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   fifo_data_q [2];
    logic [1:0]    fifo_err_q;
    logic [1:0]    count_q, count_d;
    logic          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW-3:0] word;
    logic [IW-1:0] idx;
    logic          err, push, pop;
    logic [31:0]   rd_word;

    assign word      = cmd_addr[AW-1:2];
    assign idx       = word[IW-1:0];
    assign err       = (cmd_addr[1:0] != 2'b00) || (word >= (AW-2)'(DEPTH));
    // ready is a pure function of the registered count, so no path from rsp_ready
    assign cmd_ready = count_q < 2'd2;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = rsp_valid && rsp_ready;
    assign rd_word   = (cmd_read && !err) ? mem_q[idx] : 32'h0;
    assign rsp_valid = count_q != 2'd0;
    assign rsp_rdata = rsp_valid ? fifo_data_q[rd_ptr_q] : 32'h0;
    assign rsp_err   = rsp_valid && fifo_err_q[rd_ptr_q];

    always_comb begin
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage and FIFO payload are not reset; the count gates their visibility.
    // The read word is sampled before this edge's write, giving read-old semantics.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= rd_word;
            fifo_err_q[wr_ptr_q]  <= err;
            if (!cmd_read && !err)
                for (int b = 0; b < 4; b++)
                    if (cmd_wmask[b]) mem_q[idx][8*b +: 8] <= cmd_wdata[8*b +: 8];
        end
    end
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: table-driven and directed self-checking bench for sram_responder.
module tb_sram_responder;
    localparam int DEPTH = 256;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_read = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [31:0]   cmd_wdata = '0;
    logic [3:0]    cmd_wmask = '0;
    logic          rsp_valid, rsp_ready = 1'b1, rsp_err;
    logic [31:0]   rsp_rdata;

    int n_cmp = 0, n_fail = 0;

    typedef struct {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vec [16];

    sram_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wmask(cmd_wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rd, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] m);
        cmd_valid = 1'b1; cmd_read = rd; cmd_addr = addr; cmd_wdata = wd; cmd_wmask = m;
    endtask

    // single request with rsp_ready=1: response visible one cycle after acceptance, then popped
    task automatic do_req(input string name, input vec_t v);
        @(negedge clk);
        drive(v.rd, v.addr, v.wdata, v.mask);
        chk({name, " ready"}, 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk({name, " valid"}, 32'(rsp_valid), 32'd1);
        chk({name, " rdata"}, rsp_rdata, v.exp_rdata);
        chk({name, " err"}, 32'(rsp_err), 32'(v.exp_err));
        @(posedge clk); #1;
        chk({name, " drained"}, 32'(rsp_valid), 32'd0);
    endtask

    logic [31:0] s_addr [4];
    logic [31:0] s_data [4];

    initial begin
        vec[0]  = '{1'b0, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vec[1]  = '{1'b1, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vec[2]  = '{1'b0, 32'h20,  32'h11223344, 4'hF, 32'h0,        1'b0};
        vec[3]  = '{1'b0, 32'h20,  32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
        vec[4]  = '{1'b1, 32'h20,  32'h0,        4'hF, 32'h11BB33DD, 1'b0};
        vec[5]  = '{1'b0, 32'h0,   32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
        vec[6]  = '{1'b1, 32'h22,  32'h0,        4'h0, 32'h0,        1'b1};
        vec[7]  = '{1'b1, 32'h400, 32'h0,        4'h0, 32'h0,        1'b1};
        vec[8]  = '{1'b0, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
        vec[9]  = '{1'b0, 32'h1,   32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
        vec[10] = '{1'b1, 32'h0,   32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
        vec[11] = '{1'b0, 32'h20,  32'h12345678, 4'h0, 32'h0,        1'b0};
        vec[12] = '{1'b1, 32'h20,  32'h0,        4'h0, 32'h11BB33DD, 1'b0};
        vec[13] = '{1'b0, 32'h3FC, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b0};
        vec[14] = '{1'b0, 32'h3FC, 32'h00000000, 4'hA, 32'h0,        1'b0};
        vec[15] = '{1'b1, 32'h3FC, 32'h0,        4'h0, 32'h00FF00FF, 1'b0};
        s_addr = '{32'h10, 32'h20, 32'h0, 32'h3FC};
        s_data = '{32'hDEADBEEF, 32'h11BB33DD, 32'hCAFEF00D, 32'h00FF00FF};

        // reset state, checked before any clock edge (asynchronous)
        #2;
        chk("rst valid", 32'(rsp_valid), 32'd0);
        chk("rst ready", 32'(cmd_ready), 32'd1);
        chk("rst rdata", rsp_rdata, 32'h0);
        chk("rst err", 32'(rsp_err), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) do_req($sformatf("vec%0d", i), vec[i]);

        // backpressure: two accepts, then full; a third request must be ignored
        @(negedge clk);
        rsp_ready = 1'b0;
        drive(1'b1, 32'h10, 32'h0, 4'h0);
        @(posedge clk); #1;
        chk("bp first valid", 32'(rsp_valid), 32'd1);
        chk("bp first rdata", rsp_rdata, 32'hDEADBEEF);
        chk("bp ready after 1", 32'(cmd_ready), 32'd1);
        drive(1'b1, 32'h0, 32'h0, 4'h0);
        @(posedge clk); #1;
        chk("bp full ready", 32'(cmd_ready), 32'd0);
        chk("bp hold rdata", rsp_rdata, 32'hDEADBEEF);
        drive(1'b0, 32'h10, 32'h0, 4'hF);
        @(posedge clk); #1;
        chk("bp still full", 32'(cmd_ready), 32'd0);
        chk("bp hold rdata2", rsp_rdata, 32'hDEADBEEF);
        chk("bp hold err", 32'(rsp_err), 32'd0);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp ready after pop", 32'(cmd_ready), 32'd1);
        chk("bp second rdata", rsp_rdata, 32'hCAFEF00D);
        chk("bp second valid", 32'(rsp_valid), 32'd1);
        @(posedge clk); #1;
        chk("bp drained", 32'(rsp_valid), 32'd0);
        do_req("bp ignored write", vec[1]);

        // streaming: 8 back-to-back reads, one accept per edge
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, s_addr[i%4], 32'h0, 4'h0);
            chk($sformatf("stream ready %0d", i), 32'(cmd_ready), 32'd1);
            @(posedge clk); #1;
            chk($sformatf("stream valid %0d", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("stream rdata %0d", i), rsp_rdata, s_data[i%4]);
        end
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("stream drained", 32'(rsp_valid), 32'd0);

        // reset with count = 2
        @(negedge clk);
        rsp_ready = 1'b0;
        drive(1'b1, 32'h22, 32'h0, 4'h0);
        @(posedge clk); #1;
        drive(1'b1, 32'h20, 32'h0, 4'h0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("pre-rst full", 32'(cmd_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid rst valid", 32'(rsp_valid), 32'd0);
        chk("mid rst ready", 32'(cmd_ready), 32'd1);
        chk("mid rst rdata", rsp_rdata, 32'h0);
        chk("mid rst err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        drive(1'b1, 32'h10, 32'h0, 4'h0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("post rst accept valid", 32'(rsp_valid), 32'd1);
        chk("post rst rdata", rsp_rdata, 32'hDEADBEEF);
        chk("post rst err", 32'(rsp_err), 32'd0);
        @(posedge clk); #1;
        chk("post rst no stale", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        chk("post rst no stale2", 32'(rsp_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
